axi_reset_ctrl: RTL

//  Consumer end of the AXI reset interface. Takes the raw reset and clk driven by the reset

---
 rtl/axi_reset_pkg.sv | 11 +
 rtl/axi_reset_ctrl_if.sv | 22 ++
 rtl/axi_reset_sync.sv | 19 +
 rtl/axi_reset_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/axi_reset_pkg.sv
// Shared types for the AXI reset consumer: FSM state encoding seen on state_o.
package axi_reset_pkg;

  typedef enum logic [1:0] {
    RST_SYNC  = 2'd0,
    RST_HOLD  = 2'd1,
    RST_READY = 2'd2,
    RST_SOFT  = 2'd3
  } axi_rst_state_e;

endpackage

// File: rtl/axi_reset_ctrl_if.sv
// Reset-consumer bundle: soft reset request in, ARESETn / VALID-enable / status out.
interface axi_reset_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             soft_rst_req;
  logic             aresetn;
  logic             valid_en;
  logic             soft_busy;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] soft_count;
  logic [CNT_W-1:0] release_count;

  modport slave (
    input  soft_rst_req,
    output aresetn, valid_en, soft_busy, state_o, soft_count, release_count
  );

  modport master (
    output soft_rst_req,
    input  aresetn, valid_en, soft_busy, state_o, soft_count, release_count
  );
endinterface

// File: rtl/axi_reset_sync.sv
// Async-assert / sync-deassert flop chain; dout goes high STAGES edges after rst drops.
module axi_reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic dout
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[STAGES-2:0], 1'b1};
  end

  assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/axi_reset_ctrl.sv
// AXI ARESETn generator: synchronized release, VALID guard period, soft resets and event counters.
module axi_reset_ctrl
  import axi_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 4,
  parameter int SOFT_RST_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  axi_reset_ctrl_if.slave  bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (SOFT_RST_CYCLES > 1) ? $clog2(SOFT_RST_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SOFT_LAST = SW'(SOFT_RST_CYCLES - 1);

  axi_rst_state_e   state_q;
  logic             aresetn_q;
  logic             valid_en_q;
  logic             soft_busy_q;
  logic [HW-1:0]    hold_cnt_q;
  logic [SW-1:0]    soft_cnt_q;
  logic [CNT_W-1:0] soft_count_q;
  logic [CNT_W-1:0] release_count_q;
  logic             sync_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  axi_reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (reset),
    .dout (sync_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RST_SYNC;
      aresetn_q       <= 1'b0;
      valid_en_q      <= 1'b0;
      soft_busy_q     <= 1'b0;
      hold_cnt_q      <= '0;
      soft_cnt_q      <= '0;
      soft_count_q    <= '0;
      release_count_q <= '0;
    end else begin
      case (state_q)
        RST_SYNC: begin
          if (sync_done) begin
            state_q    <= RST_HOLD;
            aresetn_q  <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        RST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q         <= RST_READY;
            valid_en_q      <= 1'b1;
            release_count_q <= sat_inc(release_count_q);
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        // Requests are only honoured here; anything seen in other states is dropped.
        RST_READY: begin
          if (bus.soft_rst_req) begin
            state_q      <= RST_SOFT;
            aresetn_q    <= 1'b0;
            valid_en_q   <= 1'b0;
            soft_busy_q  <= 1'b1;
            soft_cnt_q   <= '0;
            soft_count_q <= sat_inc(soft_count_q);
          end
        end
        RST_SOFT: begin
          if (soft_cnt_q == SOFT_LAST) begin
            state_q     <= RST_HOLD;
            aresetn_q   <= 1'b1;
            soft_busy_q <= 1'b0;
            hold_cnt_q  <= '0;
          end else begin
            soft_cnt_q <= soft_cnt_q + SW'(1);
          end
        end
        default: state_q <= RST_SYNC;
      endcase
    end
  end

  assign bus.aresetn       = aresetn_q;
  assign bus.valid_en      = valid_en_q;
  assign bus.soft_busy     = soft_busy_q;
  assign bus.state_o       = state_q;
  assign bus.soft_count    = soft_count_q;
  assign bus.release_count = release_count_q;

endmodule
